// File: rtl/cmp_sweep_pkg.sv
// cmp_sweep_pkg: shared state encoding, default width and operand-max helper
package cmp_sweep_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
    localparam int CMP_W = 5;
    function automatic int max_operand(input int w);
        return (1 << w) - 1;
    endfunction
endpackage

// File: rtl/sweep_pair_counter.sv
// sweep_pair_counter: nested-wrap (a outer, b inner) operand counter
module sweep_pair_counter
    import cmp_sweep_pkg::*;
#(
    parameter int W = CMP_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] a,
    output logic [W-1:0] b,
    output logic         at_max
);
    localparam logic [W-1:0] MAX = W'(max_operand(W));
    logic [W-1:0] a_q, b_q;
    // b steps every increment; a steps only when b wraps from max
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            a_q <= '0;
            b_q <= '0;
        end else if (inc) begin
            b_q <= b_q + 1'b1;
            a_q <= (b_q == MAX) ? a_q + 1'b1 : a_q;
        end
    end
    assign a      = a_q;
    assign b      = b_q;
    assign at_max = (a_q == MAX) && (b_q == MAX);
endmodule

// File: rtl/cmp_operand_sweep.sv
// cmp_operand_sweep: exhaustive (a, b) operand generator with valid/ready output
module cmp_operand_sweep
    import cmp_sweep_pkg::*;
#(
    parameter int W     = CMP_W,
    parameter int CNT_W = 2 * W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [W-1:0]     a,
    output logic [W-1:0]     b,
    output logic             last,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] pair_count
);
    state_t           state_q, state_d;
    logic             out_valid_q, out_valid_d;
    logic [CNT_W-1:0] pair_count_q, pair_count_d;
    logic             clr, inc, at_max, fire;

    assign fire = out_valid_q && out_ready;

    sweep_pair_counter #(.W(W)) u_cnt (
        .clk    (clk),
        .rst    (rst),
        .clr    (clr),
        .inc    (inc),
        .a      (a),
        .b      (b),
        .at_max (at_max)
    );

    // state, handshake valid and transfer count registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            out_valid_q  <= 1'b0;
            pair_count_q <= '0;
        end else begin
            state_q      <= state_d;
            out_valid_q  <= out_valid_d;
            pair_count_q <= pair_count_d;
        end
    end

    // next state: abort wins, the last transfer freezes a/b at (max, max)
    always_comb begin
        state_d      = state_q;
        out_valid_d  = out_valid_q;
        pair_count_d = pair_count_q;
        clr          = 1'b0;
        inc          = 1'b0;
        if (state_q == RUN) begin
            pair_count_d = pair_count_q + {{(CNT_W-1){1'b0}}, fire};
            if (abort) begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
            end else if (fire && at_max) begin
                state_d     = DONE;
                out_valid_d = 1'b0;
            end else begin
                inc = fire;
            end
        end else if (abort) begin
            state_d = IDLE;
        end else if (start) begin
            state_d      = RUN;
            out_valid_d  = 1'b1;
            pair_count_d = '0;
            clr          = 1'b1;
        end
    end

    assign out_valid  = out_valid_q;
    assign last       = out_valid_q && at_max;
    assign busy       = (state_q == RUN);
    assign done       = (state_q == DONE);
    assign pair_count = pair_count_q;
endmodule

// File: tb/tb_cmp_operand_sweep.sv
// tb_cmp_operand_sweep: scoreboard bench for the operand sweep generator
module tb_cmp_operand_sweep;
    localparam int W = 5;
    localparam int N = 1 << (2 * W);

    logic clk = 1'b0, rst = 1'b1, start = 1'b0, abort = 1'b0, out_ready = 1'b0;
    logic out_valid, last, busy, done;
    logic [W-1:0] a, b;
    logic [2*W:0] pair_count;

    int n_cmp = 0, n_err = 0;
    logic [2*W:0] exp_q[$];
    logic stalled = 1'b0;
    logic [2*W-1:0] held;

    cmp_operand_sweep #(.W(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .a          (a),
        .b          (b),
        .last       (last),
        .busy       (busy),
        .done       (done),
        .pair_count (pair_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_range(input int n);
        for (int i = 0; i < n; i++)
            exp_q.push_back({W'(i >> W), W'(i % (1 << W)), i == N - 1});
    endtask

    task automatic start_sweep();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("first_pair", 32'({out_valid, a, b, busy, done, pair_count}),
              32'({1'b1, 10'd0, 1'b1, 1'b0, 11'd0}));
    endtask

    task automatic wait_pair(input int ea, input int eb, input int budget);
        int k = 0;
        while (!(out_valid && a == W'(ea) && b == W'(eb)) && k < budget) begin
            @(posedge clk); #1;
            k++;
        end
        if (k >= budget) begin
            n_cmp++;
            n_err++;
            $display("FAIL wait_pair(%0d,%0d): timeout after %0d cycles", ea, eb, k);
        end
    endtask

    task automatic wait_done(input bit rnd, input int budget);
        int k = 0;
        while (!done && k < budget) begin
            if (rnd) out_ready = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            k++;
        end
        out_ready = 1'b1;
        if (k >= budget) begin
            n_cmp++;
            n_err++;
            $display("FAIL wait_done: timeout after %0d cycles", k);
        end
    endtask

    // monitor: pops one expectation per handshake, checks stall stability and last qualification
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (stalled) check("stall_hold", 32'({a, b}), 32'(held));
            if (out_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_pair: got a=%0d b=%0d required none", a, b);
                end else begin
                    check("pair", 32'({a, b, last}), 32'(exp_q.pop_front()));
                end
                stalled = 1'b0;
            end else begin
                stalled = 1'b1;
                held    = {a, b};
            end
        end else begin
            stalled = 1'b0;
            if (!rst) check("last_idle", 32'(last), 32'd0);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (10) begin
            check("reset_idle", 32'({out_valid, a, b, done, busy, pair_count}), 32'd0);
            @(posedge clk); #1;
        end
        // full sweep, no back-pressure
        out_ready = 1'b1;
        push_range(N);
        start_sweep();
        wait_done(1'b0, N + 10);
        check("full_count", 32'(pair_count), N);
        check("full_final", 32'({out_valid, a, b, busy, done}), 32'({1'b0, 5'd31, 5'd31, 1'b0, 1'b1}));
        check("full_queue", exp_q.size(), 0);
        // random back-pressure, restarted from DONE
        push_range(N);
        start_sweep();
        wait_done(1'b1, 6 * N);
        check("bp_count", 32'(pair_count), N);
        check("bp_queue", exp_q.size(), 0);
        // wrap boundary stall, then abort as (7,12) is accepted
        out_ready = 1'b1;
        push_range(7 * 32 + 13);
        start_sweep();
        wait_pair(3, 31, 200);
        out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("wrap_hold", 32'({a, b}), 32'({5'd3, 5'd31}));
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("wrap_next", 32'({a, b}), 32'({5'd4, 5'd0}));
        wait_pair(7, 12, 200);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("abort", 32'({out_valid, busy, done, pair_count}), 32'({3'b000, 11'd237}));
        check("abort_queue", exp_q.size(), 0);
        @(posedge clk); #1;
        check("abort_hold", 32'({a, b, pair_count}), 32'({5'd7, 5'd12, 11'd237}));
        // start while running is ignored
        push_range(N);
        start_sweep();
        wait_pair(10, 10, 400);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("run_start_ignored", 32'({a, b, busy}), 32'({5'd10, 5'd11, 1'b1}));
        wait_done(1'b0, N);
        check("run_start_count", 32'(pair_count), N);
        check("run_start_queue", exp_q.size(), 0);
        // start and abort together in DONE
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        abort = 1'b0;
        check("done_start_abort", 32'({out_valid, busy, done, pair_count}), 32'({3'b000, 11'd1024}));
        // reset mid-sweep at (20,5)
        push_range(20 * 32 + 5);
        start_sweep();
        wait_pair(20, 5, 700);
        out_ready = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        check("rst_mid", 32'({out_valid, a, b, last, busy, done, pair_count}), 32'd0);
        check("rst_queue", exp_q.size(), 0);
        rst = 1'b0;
        out_ready = 1'b1;
        // fresh sweep after reset
        push_range(N);
        start_sweep();
        wait_done(1'b0, N + 10);
        check("resweep_count", 32'(pair_count), N);
        check("resweep_queue", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/cmp_operand_sweep.md
Name: cmp_operand_sweep

Overview:
Hardware operand generator that sits directly upstream of comparator_5bit. It walks every (a, b) pair in row-major order: a is the outer loop and b is the inner loop, each running 0..2^W-1. Pairs are presented over a valid/ready handshake, so a downstream checker or a registered comparator wrapper can apply back-pressure. It replaces bench-side nested loops, making exhaustive compare sweeps usable in on-chip self-test.

Parameters:
W, 5, operand width in bits; a and b each span 0..2^W-1.
CNT_W, 2*W+1, width of pair_count; holds 2^(2W) with no overflow.

Ports:
clk  input  1  rising-edge clock; sole clock domain.
rst  input  1  synchronous, active-high reset.
start  input  1  begins a sweep; sampled in IDLE and DONE only.
abort  input  1  terminates a sweep in progress.
out_ready  input  1  downstream ready to accept the current pair.
out_valid  output  1  a/b/last hold a valid pair.
a  output  W  current operand a, feeds comparator .a.
b  output  W  current operand b, feeds comparator .b.
last  output  1  current pair is (2^W-1, 2^W-1); qualified by out_valid.
busy  output  1  high in RUN.
done  output  1  high in DONE (level, not pulse).
pair_count  output  CNT_W  number of handshakes completed in the current or most recent sweep.

Behaviour:
- Interface: one clock domain; reset is synchronous and active-high. Ports are named clk and rst.
- Reset (rst high at a clock edge):
  - state goes to IDLE.
  - out_valid, a, b, last, busy, done and pair_count all go to 0.
  - rst has priority over every other input, including mid-sweep.
- States: IDLE, RUN, DONE. All outputs are registered.
- IDLE:
  - start=1 and abort=0 -> RUN next cycle.
  - On that entry: a=0, b=0, out_valid=1, pair_count=0.
  - Otherwise remain in IDLE.
- RUN:
  - Transfer occurs on any cycle with out_valid && out_ready.
  - On a transfer:
    - pair_count increments by 1.
    - If b != 2^W-1: b increments.
    - If b == 2^W-1: b wraps to 0 and a increments.
  - With out_valid=1 and out_ready=0, a, b and last hold stable. No skipping, no duplicates.
  - A transfer with last=1 -> DONE next cycle. Then out_valid=0, a and b hold their final value (max, max), and pair_count = 2^(2W).
  - last is combinational from the registered a and b: (a == max) && (b == max). It is never high while out_valid=0.
  - out_valid stays 1 continuously in RUN; there are no bubbles.
  - First pair latency: out_valid rises 1 cycle after start is sampled.
  - Throughput: 1 pair per cycle with out_ready tied high. A full sweep takes 2^(2W) cycles in RUN (1024 for W=5).
- abort in RUN -> IDLE next cycle.
  - out_valid drops to 0 with no pending transfer.
  - A transfer on the abort cycle still counts in pair_count. pair_count then holds until the next start.
  - a and b hold their values.
- abort and start together in IDLE or DONE: abort wins and state stays (or becomes) IDLE.
- start while in RUN is ignored.
- DONE:
  - done=1, busy=0.
  - start (without abort) restarts exactly as from IDLE; done drops on that edge.
  - abort -> IDLE.
- Transition summary: busy=1 iff RUN; done=1 iff DONE.

Decomposition:
- Package cmp_sweep_pkg contains:
  - the state enum (IDLE, RUN, DONE), 2-bit encoding;
  - default width constant CMP_W=5;
  - a helper function for max operand (2^W-1).
- One natural sub-module: sweep_pair_counter. It is a 2W-bit nested-wrap counter with load-zero and increment-enable, and it outputs a, b and the at_max flag. The parent owns the FSM, handshake and pair_count.

Test Plan:
- Reset: hold rst for 3 cycles, then release with start=0 -> out_valid=0, a=0, b=0, done=0, busy=0, pair_count=0 for 10 cycles.
- Full sweep, W=5, out_ready=1: pulse start -> out_valid rises the next cycle with a=0, b=0. Pairs arrive in order (0,0), (0,1) .. (0,31), (1,0) .. (31,31). last is high only on (31,31). done=1 after 1024 transfers; pair_count=1024.
- Back-pressure: out_ready driven by random 50% toggling -> a and b are stable across every stall. The sequence matches the previous test exactly. Total handshakes = 1024.
- Wrap boundary: stall with a=3, b=31 for 5 cycles, then accept -> next pair is a=4, b=0, with no intermediate values.
- Abort mid-sweep: abort on the cycle pair (7,12) is accepted -> IDLE next cycle. out_valid=0, pair_count=237, done=0.
- Simultaneous events:
  - start+abort in DONE -> IDLE with done=0.
  - start in RUN -> no restart; the sequence continues.
  - rst asserted at pair (20,5) -> all outputs are 0 next cycle.
  - A new start then sweeps again from (0,0).
